// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared timing types for the VGA timing generator. Holds the
//                mode descriptor struct, the standard mode presets and a
//                helper that sums the four segments of a line or a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // One display mode: horizontal fields in pixels, vertical fields in
    // lines, and the active level of each sync (0 = active-low).
    typedef struct packed {
        logic [15:0] h_visible;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_visible;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_visible: 16'd640,  h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_visible: 16'd480,  v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_timing_t XGA_1024x768_60 = '{
        h_visible: 16'd1024, h_fp: 16'd24, h_sync: 16'd136, h_bp: 16'd160,
        v_visible: 16'd768,  v_fp: 16'd3,  v_sync: 16'd6,   v_bp: 16'd29,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // Length of a whole line (pixels) or frame (lines).
    function automatic int unsigned timing_total(
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return visible + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Timing bus between the generator and the pixel pipeline.
//                master : generator (drives sync, de, coordinates, strobes;
//                         receives the pixel clock-enable)
//                slave  : consumer (sees timing, drives ce)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 10
);
    logic          ce;
    logic          hs;
    logic          vs;
    logic          de;
    logic [HW-1:0] hc_visible;
    logic [VW-1:0] vc_visible;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  ce,
        output hs, vs, de, hc_visible, vc_visible, line_start, frame_start
    );

    modport slave (
        output ce,
        input  hs, vs, de, hc_visible, vc_visible, line_start, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_line
//  Description : ce-qualified delay for {hs, vs, de}.
//                DELAY = 0 : single register loaded with the values of the
//                            position the counters are moving to, so the
//                            output lines up with the coordinate registers.
//                DELAY > 0 : DELAY-deep shift register loaded with the values
//                            of the current position, giving exactly DELAY
//                            ce steps of lag relative to the coordinates.
//  Ports       : clk_vga, rst (async, active-high), ce,
//                i_raw_cur / i_raw_nxt {hs,vs,de} at current / next position,
//                o_sync delayed {hs,vs,de}
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int unsigned DELAY = 0,
    parameter bit          H_POL = 1'b0,
    parameter bit          V_POL = 1'b0
) (
    input  wire        clk_vga,
    input  wire        rst,
    input  wire        ce,
    input  wire  [2:0] i_raw_cur,
    input  wire  [2:0] i_raw_nxt,
    output logic [2:0] o_sync
);
    // Inactive sync levels, de low.
    localparam logic [2:0] c_idle = {~H_POL, ~V_POL, 1'b0};

    if (DELAY == 0) begin : g_pass
        logic [2:0] r_q;
        wire  [2:0] w_unused_cur = i_raw_cur;

        always_ff @(posedge clk_vga or posedge rst) begin
            if (rst) begin
                r_q <= c_idle;
            end else if (ce) begin
                r_q <= i_raw_nxt;
            end
        end

        assign o_sync = r_q;
    end else begin : g_shift
        logic [2:0] r_stage [DELAY];
        wire  [2:0] w_unused_nxt = i_raw_nxt;

        always_ff @(posedge clk_vga or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(DELAY); i++) begin
                    r_stage[i] <= c_idle;
                end
            end else if (ce) begin
                r_stage[0] <= i_raw_cur;
                for (int i = 1; i < int'(DELAY); i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_sync = r_stage[DELAY-1];
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA/SVGA timing generator. Pixel and line
//                counters advance on ce; the visible coordinates are
//                registered from the next count so they track the counters
//                with no lag. hs/vs/de pass through a ce-qualified delay line.
//  Ports       : clk_vga  pixel clock
//                rst      asynchronous active-high reset
//                bus      timing bus (master): ce in; hs, vs, de,
//                         hc_visible, vc_visible, line_start, frame_start out
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned DELAY     = 0
) (
    input wire               clk_vga,
    input wire               rst,
    vga_timing_gen_if.master bus
);
    localparam int unsigned c_h_total = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_v_total = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int unsigned c_hw      = $clog2(c_h_total);
    localparam int unsigned c_vw      = $clog2(c_v_total);

    localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_total - 1);
    localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_total - 1);
    localparam logic [c_hw-1:0] c_h_vis    = c_hw'(H_VISIBLE);
    localparam logic [c_vw-1:0] c_v_vis    = c_vw'(V_VISIBLE);
    localparam logic [c_hw-1:0] c_hs_first = c_hw'(H_VISIBLE + H_FP);
    localparam logic [c_hw-1:0] c_hs_last  = c_hw'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [c_vw-1:0] c_vs_first = c_vw'(V_VISIBLE + V_FP);
    localparam logic [c_vw-1:0] c_vs_last  = c_vw'(V_VISIBLE + V_FP + V_SYNC - 1);

    if (H_VISIBLE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_VISIBLE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        DELAY > 15) begin : g_bad_params
        $error("vga_timing_gen: every timing field must be >= 1 and DELAY <= 15");
    end

    logic [c_hw-1:0] r_hc;
    logic [c_vw-1:0] r_vc;
    logic [c_hw-1:0] r_hc_vis;
    logic [c_vw-1:0] r_vc_vis;

    logic [c_hw-1:0] w_hc_nxt;
    logic [c_vw-1:0] w_vc_nxt;
    logic            w_hc_wrap;
    logic [2:0]      w_raw_cur;
    logic [2:0]      w_raw_nxt;
    logic [2:0]      w_sync;

    // {hs, vs, de} at a given position, sync levels already polarity-applied.
    function automatic logic [2:0] raw_of(input logic [c_hw-1:0] h,
                                          input logic [c_vw-1:0] v);
        logic hs_on;
        logic vs_on;
        logic vis;
        hs_on = (h >= c_hs_first) && (h <= c_hs_last);
        vs_on = (v >= c_vs_first) && (v <= c_vs_last);
        vis   = (h < c_h_vis) && (v < c_v_vis);
        return {hs_on ? H_POL : ~H_POL, vs_on ? V_POL : ~V_POL, vis};
    endfunction

    assign w_hc_wrap = (r_hc == c_h_last);
    assign w_hc_nxt  = w_hc_wrap ? '0 : r_hc + 1'b1;
    assign w_vc_nxt  = !w_hc_wrap        ? r_vc :
                       (r_vc == c_v_last) ? '0   : r_vc + 1'b1;

    assign w_raw_cur = raw_of(r_hc, r_vc);
    assign w_raw_nxt = raw_of(w_hc_nxt, w_vc_nxt);

    // Coordinates are loaded from the next count so they describe the
    // position held in r_hc/r_vc after the same edge.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_hc     <= '0;
            r_vc     <= '0;
            r_hc_vis <= '0;
            r_vc_vis <= '0;
        end else if (bus.ce) begin
            r_hc     <= w_hc_nxt;
            r_vc     <= w_vc_nxt;
            r_hc_vis <= (w_hc_nxt < c_h_vis) ? w_hc_nxt : '0;
            r_vc_vis <= (w_vc_nxt < c_v_vis) ? w_vc_nxt : '0;
        end
    end

    vga_delay_line #(
        .DELAY (DELAY),
        .H_POL (H_POL),
        .V_POL (V_POL)
    ) u_delay (
        .clk_vga   (clk_vga),
        .rst       (rst),
        .ce        (bus.ce),
        .i_raw_cur (w_raw_cur),
        .i_raw_nxt (w_raw_nxt),
        .o_sync    (w_sync)
    );

    assign bus.hs          = w_sync[2];
    assign bus.vs          = w_sync[1];
    assign bus.de          = w_sync[0];
    assign bus.hc_visible  = r_hc_vis;
    assign bus.vc_visible  = r_vc_vis;
    // ce is only high for one clk per position step, so these are single-clk
    // pulses even when ce is sparse.
    assign bus.line_start  = bus.ce && (r_hc == '0);
    assign bus.frame_start = bus.ce && (r_hc == '0) && (r_vc == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Bench for vga_timing_gen. Three instances (640x480 default,
//                a tiny mode with DELAY=3 and active-high syncs, XGA with
//                H_POL=1 and DELAY=15) share clk/rst/ce. Expected outputs come
//                from the position reached after k ce steps: x = k mod H_TOTAL,
//                y = (k div H_TOTAL) mod V_TOTAL.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int HV  [3] = '{640, 8, int'(XGA_1024x768_60.h_visible)};
    localparam int HF  [3] = '{16,  2, int'(XGA_1024x768_60.h_fp)};
    localparam int HS  [3] = '{96,  3, int'(XGA_1024x768_60.h_sync)};
    localparam int HB  [3] = '{48,  2, int'(XGA_1024x768_60.h_bp)};
    localparam int VV  [3] = '{480, 4, int'(XGA_1024x768_60.v_visible)};
    localparam int VF  [3] = '{10,  1, int'(XGA_1024x768_60.v_fp)};
    localparam int VS  [3] = '{2,   2, int'(XGA_1024x768_60.v_sync)};
    localparam int VB  [3] = '{33,  1, int'(XGA_1024x768_60.v_bp)};
    localparam bit HP  [3] = '{1'b0, 1'b1, 1'b1};
    localparam bit VP  [3] = '{1'b0, 1'b1, 1'b0};
    localparam int DLY [3] = '{0, 3, 15};

    localparam int HW0 = $clog2(HV[0] + HF[0] + HS[0] + HB[0]);
    localparam int VW0 = $clog2(VV[0] + VF[0] + VS[0] + VB[0]);
    localparam int HW1 = $clog2(HV[1] + HF[1] + HS[1] + HB[1]);
    localparam int VW1 = $clog2(VV[1] + VF[1] + VS[1] + VB[1]);
    localparam int HW2 = $clog2(HV[2] + HF[2] + HS[2] + HB[2]);
    localparam int VW2 = $clog2(VV[2] + VF[2] + VS[2] + VB[2]);

    logic clk_vga = 1'b0;
    logic rst     = 1'b1;
    logic ce      = 1'b0;

    always #5 clk_vga = ~clk_vga;

    vga_timing_gen_if #(.HW(HW0), .VW(VW0)) if0 ();
    vga_timing_gen_if #(.HW(HW1), .VW(VW1)) if1 ();
    vga_timing_gen_if #(.HW(HW2), .VW(VW2)) if2 ();

    assign if0.ce = ce;
    assign if1.ce = ce;
    assign if2.ce = ce;

    vga_timing_gen dut0 (.clk_vga(clk_vga), .rst(rst), .bus(if0));

    vga_timing_gen #(
        .H_VISIBLE(HV[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_VISIBLE(VV[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .H_POL(HP[1]), .V_POL(VP[1]), .DELAY(DLY[1])
    ) dut1 (.clk_vga(clk_vga), .rst(rst), .bus(if1));

    vga_timing_gen #(
        .H_VISIBLE(HV[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
        .V_VISIBLE(VV[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]),
        .H_POL(HP[2]), .V_POL(VP[2]), .DELAY(DLY[2])
    ) dut2 (.clk_vga(clk_vga), .rst(rst), .bus(if2));

    // {hs, vs, de, line_start, frame_start, hc_visible[15:0], vc_visible[15:0]}
    logic [36:0] obs [3];
    assign obs[0] = {if0.hs, if0.vs, if0.de, if0.line_start, if0.frame_start,
                     16'(if0.hc_visible), 16'(if0.vc_visible)};
    assign obs[1] = {if1.hs, if1.vs, if1.de, if1.line_start, if1.frame_start,
                     16'(if1.hc_visible), 16'(if1.vc_visible)};
    assign obs[2] = {if2.hs, if2.vs, if2.de, if2.line_start, if2.frame_start,
                     16'(if2.hc_visible), 16'(if2.vc_visible)};

    longint k [3];
    int     n_vec = 0;
    int     n_err = 0;
    logic [36:0] expv;

    // Expected outputs of instance i after k ce steps since reset, with the
    // given ce level in the current cycle. Sync/de show the position DELAY
    // steps back; before any history exists they sit at their idle levels
    // (and with no delay, position 0 right after reset is still idle).
    function automatic logic [36:0] model(input int i, input longint kk, input bit cev);
        longint ht, vt, x, y, xd, yd, first;
        bit hs_on, vs_on, de, ls, fs;
        longint hcv, vcv;
        ht = HV[i] + HF[i] + HS[i] + HB[i];
        vt = VV[i] + VF[i] + VS[i] + VB[i];
        x  = kk % ht;
        y  = (kk / ht) % vt;
        hs_on = 1'b0;
        vs_on = 1'b0;
        de    = 1'b0;
        first = (DLY[i] == 0) ? 1 : DLY[i];
        if (kk >= first) begin
            xd = (kk - DLY[i]) % ht;
            yd = ((kk - DLY[i]) / ht) % vt;
            hs_on = (xd >= HV[i] + HF[i]) && (xd < HV[i] + HF[i] + HS[i]);
            vs_on = (yd >= VV[i] + VF[i]) && (yd < VV[i] + VF[i] + VS[i]);
            de    = (xd < HV[i]) && (yd < VV[i]);
        end
        ls  = cev && (x == 0);
        fs  = ls && (y == 0);
        hcv = (x < HV[i]) ? x : 0;
        vcv = (y < VV[i]) ? y : 0;
        return {hs_on ? HP[i] : !HP[i], vs_on ? VP[i] : !VP[i], de, ls, fs,
                16'(hcv), 16'(vcv)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b0;
        for (int i = 0; i < 3; i++) k[i] = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_vga);
            for (int i = 0; i < 3; i++) begin
                expv = model(i, k[i], ce);
                n_vec++;
                if (obs[i] !== expv) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL reset inst%0d: got %h expected %h", i, obs[i], expv);
                end
            end
        end
        @(posedge clk_vga);
        #1 rst = 1'b0;
    endtask

    task automatic test_free_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            ce = 1'b1;
            @(negedge clk_vga);
            for (int i = 0; i < 3; i++) begin
                expv = model(i, k[i], ce);
                n_vec++;
                if (obs[i] !== expv) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL free_run inst%0d k=%0d: got %h expected %h",
                                 i, k[i], obs[i], expv);
                end
            end
            @(posedge clk_vga);
            for (int i = 0; i < 3; i++) k[i]++;
            #1;
        end
    endtask

    task automatic test_alternating_ce(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            ce = (c % 2 == 0);
            @(negedge clk_vga);
            for (int i = 0; i < 3; i++) begin
                expv = model(i, k[i], ce);
                n_vec++;
                if (obs[i] !== expv) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL alternating_ce inst%0d k=%0d ce=%0b: got %h expected %h",
                                 i, k[i], ce, obs[i], expv);
                end
            end
            @(posedge clk_vga);
            if (ce) for (int i = 0; i < 3; i++) k[i]++;
            #1;
        end
    endtask

    task automatic test_sparse_ce(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            ce = ($urandom_range(0, 3) != 0);
            @(negedge clk_vga);
            for (int i = 0; i < 3; i++) begin
                expv = model(i, k[i], ce);
                n_vec++;
                if (obs[i] !== expv) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL sparse_ce inst%0d k=%0d ce=%0b: got %h expected %h",
                                 i, k[i], ce, obs[i], expv);
                end
            end
            @(posedge clk_vga);
            if (ce) for (int i = 0; i < 3; i++) k[i]++;
            #1;
        end
    endtask

    // Reset lands between clock edges; outputs must go idle at once.
    task automatic test_mid_frame_reset();
        ce = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            k[i] = 0;
            expv = model(i, k[i], ce);
            n_vec++;
            if (obs[i] !== expv) begin
                n_err++;
                if (n_err <= 20)
                    $display("FAIL mid_frame_reset inst%0d: got %h expected %h", i, obs[i], expv);
            end
        end
        @(posedge clk_vga);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run(2700);
        test_alternating_ce(3400);
        test_sparse_ce(5000);
        test_mid_frame_reset();
        test_free_run(300);
        test_sparse_ce(600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/SVGA timing generator. It succeeds the fixed-mode 640x480 and 1024x768 drivers with a single block configurable for any mode. The block produces hs, vs and data-enable (de), visible-pixel coordinates, and line/frame strobes. It adds a pixel clock-enable, programmable sync polarity, and a DELAY stage that aligns sync/de with a downstream pixel pipeline. It sits between the pixel clock domain and the framebuffer/pixel-generator logic.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hs active level (0 = active-low)
V_POL, 0, vs active level (0 = active-low)
DELAY, 0, ce-qualified cycles by which hs/vs/de lag the coordinates (0..15)
Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
clk_vga  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
ce  in  1  pixel enable; counters and pipeline advance only when 1
hs  out  1  horizontal sync, level per H_POL, delayed by DELAY
vs  out  1  vertical sync, level per V_POL, delayed by DELAY
de  out  1  visible-area flag, delayed by DELAY
hc_visible  out  HW  visible x coordinate, 0 outside the visible area
vc_visible  out  VW  visible y coordinate, 0 outside the visible area
line_start  out  1  one-clk strobe at hc==0
frame_start  out  1  one-clk strobe at hc==0 && vc==0

Behaviour:
- Line order: visible [0, H_VISIBLE-1], front porch, sync [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], back porch. The vertical axis uses the same order, in lines.
- Internal counters: hc in 0..H_TOTAL-1, vc in 0..V_TOTAL-1.
  - On ce: hc increments.
  - At hc==H_TOTAL-1: hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 together with the hc wrap: vc wraps to 0.
  - When ce=0, all state and all outputs hold.
- hc_visible/vc_visible: registered, updated in the same edge as the counters, so they describe the current position with zero latency.
  - hc_visible = hc when hc<H_VISIBLE, else 0.
  - vc_visible = vc when vc<V_VISIBLE, else 0.
- Raw sync and de:
  - hs_raw is active while hc is in the sync range.
  - vs_raw is active while vc is in the vertical sync range, for whole lines (changes only at hc==0).
  - de_raw = (hc<H_VISIBLE) && (vc<V_VISIBLE).
- Delay line: hs/vs/de equal the raw values delayed by DELAY ce-qualified stages. DELAY=0 means they are registered alongside the coordinates, with no extra lag.
- Strobes:
  - line_start = ce && (hc==0).
  - frame_start = ce && (hc==0) && (vc==0).
  - Each strobe is high for exactly one clk cycle per occurrence, even when ce is sparse.
- Reset values (asynchronous, take effect immediately, including mid-frame):
  - hc=0, vc=0.
  - hc_visible=0, vc_visible=0, de=0.
  - hs = ~H_POL and vs = ~V_POL (inactive level).
  - All delay stages cleared to inactive/de=0.
- After reset release: the first ce cycle sees position (0,0), so line_start and frame_start both assert.
- Width rules: all comparisons use HW/VW-bit unsigned arithmetic. Parameter sums are checked at elaboration: each field must be ≥1, and DELAY must be ≤15.

Decomposition:
- Package vga_timing_pkg holds:
  - a vga_timing_t struct with the 8 timing fields and 2 polarity fields;
  - localparam presets VGA_640x480_60 and XGA_1024x768_60;
  - a function that computes the totals.
- Sub-module vga_delay_line: a DELAY-stage, ce-qualified shift register for {hs,vs,de} with asynchronous reset to the inactive values. It is a pass-through register when DELAY=0.

Test Plan:
1. Defaults, ce=1, after reset: de high for exactly 640 consecutive cycles per visible line; hs low for hc 656..751 (96 cycles); line_start period 800 cycles.
2. Defaults, ce=1: vs low for lines 490..491 (1600 cycles); frame_start period 420000 cycles; vc_visible runs 0..479 and then holds 0 through blanking.
3. rst asserted at hc=300, vc=200: all outputs reach reset values within the same cycle. On release, the first ce gives frame_start=1, hc_visible=0, vc_visible=0.
4. ce toggling 1,0,1,0: line period is 1600 clk cycles, outputs are stable while ce=0, and line_start/frame_start are 1 clk wide.
5. DELAY=3: de rises exactly 3 ce-cycles after position (0,0) appears on hc_visible/vc_visible; hs/vs lag by 3 as well.
6. XGA preset (1024,24,136,160 / 768,3,6,29) with H_POL=1: hs high for hc 1048..1183; line period 1344; frame period 1344*806 cycles.
